// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch queue.
package ifetch_pkg;
    localparam logic [31:0] NOP_INSTR   = 32'hE1A00000;
    localparam int          INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry synchronous FIFO of fetch entries; pointers carry an extra wrap bit.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             din,
    output fetch_entry_t             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr, rd_ptr;
    fetch_entry_t mem [DEPTH];

    assign count = wr_ptr - rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = count == (AW + 1)'(DEPTH);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: PC sequencing, 1-cycle imem handshake and prefetch queue feeding decode.
// Define IFETCH_PERF_EN to add saturating perf_fetched / perf_flushed counters.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               bubble,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    input  logic               id_ready
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc, req_pc;
    logic              inflight, drop, accept, push, pop, full, empty, bub;
    logic [CW-1:0]     count;
    fetch_entry_t      din, head;

    // Reset gates the combinational outputs so they drop to zero immediately.
    assign bub       = bubble & rst;
    assign imem_req  = rst & ~redirect & ~full & (count + CW'(inflight) < CW'(DEPTH));
    assign imem_addr = pc;
    assign accept    = imem_req & imem_gnt;
    assign push      = imem_rvalid & inflight & ~drop & ~redirect;
    assign pop       = ~empty & id_ready & ~bub & ~redirect;
    assign din       = '{pc: 32'(req_pc), instr: 32'(imem_rdata)};

    assign id_valid = bub | ~empty;
    assign id_instr = bub ? INSTR_W'(NOP_INSTR) : (empty ? '0 : INSTR_W'(head.instr));
    assign id_pc    = (bub | empty) ? '0 : ADDR_W'(head.pc);

    ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            drop     <= 1'b0;
        end else begin
            drop <= redirect & inflight;
            if (redirect) begin
                pc       <= redirect_pc & ~ADDR_W'(3);
                inflight <= 1'b0;
            end else begin
                if (accept) begin
                    pc     <= pc + ADDR_W'(INSTR_BYTES);
                    req_pc <= pc;
                end
                inflight <= accept | (inflight & ~imem_rvalid);
            end
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= sat_add(perf_fetched, 32'(accept));
            if (redirect) perf_flushed <= sat_add(perf_flushed, 32'(count) + 32'(inflight));
        end
    end
`endif
endmodule
